// File: rtl/core_regfile_pkg.sv
// core_regfile_pkg: address-map layout shared by the register file and its users.
// Special registers sit directly above the general-purpose bank, so every
// offset here is relative to NUM_GP.
package core_regfile_pkg;

    localparam int unsigned PC_OFS   = 0;
    localparam int unsigned ZERO_OFS = 1;
    localparam int unsigned ONE_OFS  = 2;
    localparam int unsigned ONES_OFS = 3;
    localparam int unsigned BUS_OFS  = 4;
    localparam int unsigned MAP_SPAN = 5;

    typedef enum logic [2:0] {
        REGION_GP,
        REGION_PC,
        REGION_ZERO,
        REGION_ONE,
        REGION_ONES,
        REGION_BUS,
        REGION_NONE
    } regfile_region_e;

    // Classifies an address into its region given the size of the GP bank.
    function automatic regfile_region_e addr_region(input int unsigned addr,
                                                    input int unsigned num_gp);
        regfile_region_e region;
        if (addr < num_gp) begin
            region = REGION_GP;
        end else if (addr == num_gp + PC_OFS) begin
            region = REGION_PC;
        end else if (addr == num_gp + ZERO_OFS) begin
            region = REGION_ZERO;
        end else if (addr == num_gp + ONE_OFS) begin
            region = REGION_ONE;
        end else if (addr == num_gp + ONES_OFS) begin
            region = REGION_ONES;
        end else if (addr == num_gp + BUS_OFS) begin
            region = REGION_BUS;
        end else begin
            region = REGION_NONE;
        end
        return region;
    endfunction

endpackage

// File: rtl/core_regfile_bus_latch.sv
// core_regfile_bus_latch: single-entry holding register for words arriving
// from the memory bus. A pop in the same cycle frees the slot, so a new word
// can be accepted back-to-back without a bubble.
module core_regfile_bus_latch #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_valid,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              bus_pop,
    output logic              bus_ready,
    output logic              bus_full,
    output logic [DATA_W-1:0] latch_data
);

    logic              full_q;
    logic              full_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              accept;

    // Handshake: free slot or one being emptied this cycle; accept overrides pop.
    always_comb begin
        bus_ready = !full_q || bus_pop;
        accept    = bus_valid && bus_ready;
        full_d    = full_q;
        data_d    = data_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = bus_data;
        end else if (bus_pop) begin
            full_d = 1'b0;
        end
    end

    // Latch state; the data word is kept after a pop so reads still see it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign bus_full   = full_q;
    assign latch_data = data_q;

endmodule

// File: rtl/core_register_file.sv
// core_register_file: GP bank, program counter, constants and bus latch behind
// one address space, with two combinational read ports, one write port and a
// pending-write scoreboard covering the GP registers and the PC.
// Optional macro REGFILE_BYPASS_EN forwards the write port to matching reads
// in the same cycle; when undefined, reads see only the registered state.
module core_register_file
    import core_regfile_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       NUM_GP   = 11,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int unsigned       MON_IDX  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              rd_a_busy,
    output logic              rd_b_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] pc_out,
    input  logic              bus_valid,
    input  logic [DATA_W-1:0] bus_data,
    output logic              bus_ready,
    input  logic              bus_pop,
    output logic              bus_full,
    output logic [DATA_W-1:0] mon_out
);

    // The PC shares the scoreboard with the GP bank and sits just above it.
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(NUM_GP + PC_OFS);

    logic [DATA_W-1:0] gp_q [NUM_GP];
    logic [DATA_W-1:0] gp_d [NUM_GP];
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;
    logic [NUM_GP:0]   sb_q;
    logic [NUM_GP:0]   sb_d;
    logic [DATA_W-1:0] latch_data;

    core_regfile_bus_latch #(
        .DATA_W (DATA_W)
    ) u_bus_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .bus_pop    (bus_pop),
        .bus_ready  (bus_ready),
        .bus_full   (bus_full),
        .latch_data (latch_data)
    );

    function automatic regfile_region_e region_of(input logic [ADDR_W-1:0] a);
        return addr_region(32'(a), NUM_GP);
    endfunction

    // Registered value at an address; constants decode directly, unmapped reads 0.
    function automatic logic [DATA_W-1:0] stored_value(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        case (region_of(a))
            REGION_GP: begin
                for (int i = 0; i < NUM_GP; i++) begin
                    if (a == ADDR_W'(i)) begin
                        v = gp_q[i];
                    end
                end
            end
            REGION_PC:   v = pc_q;
            REGION_ZERO: v = '0;
            REGION_ONE:  v = DATA_W'(1);
            REGION_ONES: v = '1;
            REGION_BUS:  v = latch_data;
            default:     v = '0;
        endcase
        return v;
    endfunction

    // Scoreboard bit of an address; only GP and PC can ever be pending.
    function automatic logic stored_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = 1'b0;
        for (int i = 0; i <= NUM_GP; i++) begin
            if (a == ADDR_W'(i)) begin
                b = sb_q[i];
            end
        end
        return b;
    endfunction

`ifdef REGFILE_BYPASS_EN
    logic wr_hits_reg;

    // Read ports with same-cycle forwarding of a GP/PC write.
    always_comb begin
        wr_hits_reg = wr_en && ((region_of(wr_addr) == REGION_GP) ||
                                (region_of(wr_addr) == REGION_PC));
        rd_a_data = stored_value(rd_a_addr);
        rd_b_data = stored_value(rd_b_addr);
        rd_a_busy = stored_busy(rd_a_addr);
        rd_b_busy = stored_busy(rd_b_addr);
        if (wr_hits_reg && (rd_a_addr == wr_addr)) begin
            rd_a_data = wr_data;
            rd_a_busy = rsv_en && (rsv_addr == rd_a_addr);
        end
        if (wr_hits_reg && (rd_b_addr == wr_addr)) begin
            rd_b_data = wr_data;
            rd_b_busy = rsv_en && (rsv_addr == rd_b_addr);
        end
    end
`else
    // Read ports reflect only the state after the last edge.
    always_comb begin
        rd_a_data = stored_value(rd_a_addr);
        rd_b_data = stored_value(rd_b_addr);
        rd_a_busy = stored_busy(rd_a_addr);
        rd_b_busy = stored_busy(rd_b_addr);
    end
`endif

    // Next-state for GP bank, PC (write beats increment) and scoreboard (reserve beats clear).
    always_comb begin
        gp_d = gp_q;
        pc_d = pc_q;
        sb_d = sb_q;
        for (int i = 0; i < NUM_GP; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                gp_d[i] = wr_data;
            end
        end
        if (wr_en && (wr_addr == PC_ADDR)) begin
            pc_d = wr_data;
        end else if (pc_inc) begin
            pc_d = pc_q + DATA_W'(1);
        end
        for (int i = 0; i <= NUM_GP; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                sb_d[i] = 1'b0;
            end
            if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
                sb_d[i] = 1'b1;
            end
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GP; i++) begin
                gp_q[i] <= '0;
            end
            pc_q <= RESET_PC;
            sb_q <= '0;
        end else begin
            gp_q <= gp_d;
            pc_q <= pc_d;
            sb_q <= sb_d;
        end
    end

    assign pc_out  = pc_q;
    assign mon_out = gp_q[MON_IDX];

endmodule

// File: tb/tb_core_register_file.sv
// tb_core_register_file: directed and random checks of core_register_file
// against a behavioural model of the architectural state.
module tb_core_register_file;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int NUM_GP  = 11;
    localparam int MON_IDX = 7;
    localparam int PC_A    = NUM_GP;
    localparam int BUS_A   = NUM_GP + 4;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] rd_a_data;
    logic [DATA_W-1:0] rd_b_data;
    logic              rd_a_busy;
    logic              rd_b_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              pc_inc;
    logic [DATA_W-1:0] pc_out;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_ready;
    logic              bus_pop;
    logic              bus_full;
    logic [DATA_W-1:0] mon_out;

    int compared;
    int mismatched;

    int m_gp [NUM_GP];
    int m_pc;
    int m_bus;
    bit m_full;
    bit m_sb [NUM_GP+1];

    core_register_file #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_GP   (NUM_GP),
        .RESET_PC (16'h0000),
        .MON_IDX  (MON_IDX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_a_addr (rd_a_addr),
        .rd_b_addr (rd_b_addr),
        .rd_a_data (rd_a_data),
        .rd_b_data (rd_b_data),
        .rd_a_busy (rd_a_busy),
        .rd_b_busy (rd_b_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .pc_inc    (pc_inc),
        .pc_out    (pc_out),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_ready (bus_ready),
        .bus_pop   (bus_pop),
        .bus_full  (bus_full),
        .mon_out   (mon_out)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NUM_GP; i++) m_gp[i] = 0;
        for (int i = 0; i <= NUM_GP; i++) m_sb[i] = 1'b0;
        m_pc   = 0;
        m_bus  = 0;
        m_full = 1'b0;
    endtask

    function automatic int exp_read(input int a);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && int'(wr_addr) == a && a <= PC_A) return int'(wr_data);
`endif
        if (a < NUM_GP)      return m_gp[a];
        if (a == PC_A)       return m_pc;
        if (a == NUM_GP + 1) return 0;
        if (a == NUM_GP + 2) return 1;
        if (a == NUM_GP + 3) return 65535;
        if (a == BUS_A)      return m_bus;
        return 0;
    endfunction

    function automatic int exp_busy(input int a);
        if (a > PC_A) return 0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && int'(wr_addr) == a) return (rsv_en && int'(rsv_addr) == a) ? 1 : 0;
`endif
        return m_sb[a] ? 1 : 0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check_val({tag, ".rd_a_data"}, 32'(rd_a_data), exp_read(int'(rd_a_addr)));
        check_val({tag, ".rd_b_data"}, 32'(rd_b_data), exp_read(int'(rd_b_addr)));
        check_val({tag, ".rd_a_busy"}, 32'(rd_a_busy), exp_busy(int'(rd_a_addr)));
        check_val({tag, ".rd_b_busy"}, 32'(rd_b_busy), exp_busy(int'(rd_b_addr)));
        check_val({tag, ".pc_out"},    32'(pc_out),    m_pc);
        check_val({tag, ".bus_full"},  32'(bus_full),  m_full ? 1 : 0);
        check_val({tag, ".bus_ready"}, 32'(bus_ready), (!m_full || bus_pop) ? 1 : 0);
        check_val({tag, ".mon_out"},   32'(mon_out),   m_gp[MON_IDX]);
    endtask

    task automatic apply_stimulus(input bit we, input int wa, input int wd,
                                  input bit re, input int ra, input bit pi,
                                  input bit bv, input int bd, input bit bp,
                                  input int aa, input int ab);
        wr_en     = we;
        wr_addr   = ADDR_W'(wa);
        wr_data   = DATA_W'(wd);
        rsv_en    = re;
        rsv_addr  = ADDR_W'(ra);
        pc_inc    = pi;
        bus_valid = bv;
        bus_data  = DATA_W'(bd);
        bus_pop   = bp;
        rd_a_addr = ADDR_W'(aa);
        rd_b_addr = ADDR_W'(ab);
        #1;
    endtask

    // Compute the architectural effect of the current inputs, then commit at the edge.
    task automatic advance_clock();
        int n_gp [NUM_GP];
        int n_pc;
        int n_bus;
        bit n_full;
        bit n_sb [NUM_GP+1];
        int wa;
        int ra;
        wa = int'(wr_addr);
        ra = int'(rsv_addr);
        n_gp = m_gp;
        n_sb = m_sb;
        n_pc = m_pc;
        n_bus = m_bus;
        n_full = m_full;
        if (wr_en && wa < NUM_GP) n_gp[wa] = int'(wr_data);
        if (wr_en && wa == PC_A) n_pc = int'(wr_data);
        else if (pc_inc) n_pc = (m_pc + 1) % 65536;
        if (bus_valid && (!m_full || bus_pop)) begin
            n_bus = int'(bus_data);
            n_full = 1'b1;
        end else if (bus_pop) begin
            n_full = 1'b0;
        end
        if (wr_en && wa <= PC_A) n_sb[wa] = 1'b0;
        if (rsv_en && ra <= PC_A) n_sb[ra] = 1'b1;
        @(posedge clk);
        m_gp = n_gp;
        m_sb = n_sb;
        m_pc = n_pc;
        m_bus = n_bus;
        m_full = n_full;
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        model_reset();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #11;
        rst_n = 1'b1;
        #1;

        $display("[TB] reset defaults over all addresses");
        for (int a = 0; a < 16; a++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, a, 15 - a);
            check_output("reset_map");
        end
        check_val("reset.one",  32'(rd_a_data), 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, NUM_GP + 2, NUM_GP + 3);
        check_val("const.one",  32'(rd_a_data), 32'h0001);
        check_val("const.ones", 32'(rd_b_data), 32'hFFFF);

        $display("[TB] GP3 write and monitor");
        apply_stimulus(1, 3, 'h1234, 0, 0, 0, 0, 0, 0, 3, 3);
        check_output("gp3_wr");
        advance_clock();
        apply_stimulus(1, 7, 'hBEEF, 0, 0, 0, 0, 0, 0, 3, 3);
        check_output("gp3_rd");
        check_val("gp3.value", 32'(rd_a_data), 32'h1234);
        advance_clock();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3);
        check_output("gp7_rd");
        check_val("mon.value", 32'(mon_out), 32'hBEEF);

        $display("[TB] PC write priority and wrap");
        apply_stimulus(1, PC_A, 'hFFFF, 0, 0, 1, 0, 0, 0, PC_A, 0);
        check_output("pc_wr");
        advance_clock();
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, PC_A, 0);
        check_output("pc_ffff");
        check_val("pc.written", 32'(pc_out), 32'hFFFF);
        advance_clock();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, PC_A, 0);
        check_output("pc_wrap");
        check_val("pc.wrapped", 32'(pc_out), 32'h0000);

        $display("[TB] bus latch handshake");
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 'hA5A5, 0, BUS_A, 0);
        check_output("bus_acc1");
        advance_clock();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 'h5A5A, 0, BUS_A, 0);
        check_output("bus_stall");
        check_val("bus.ready_low", 32'(bus_ready), 0);
        advance_clock();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 'h5A5A, 1, BUS_A, 0);
        check_output("bus_held");
        check_val("bus.held", 32'(rd_a_data), 32'hA5A5);
        advance_clock();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, BUS_A, 0);
        check_output("bus_swap");
        check_val("bus.swapped", 32'(rd_a_data), 32'h5A5A);
        advance_clock();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, BUS_A, 0);
        check_output("bus_empty");
        check_val("bus.last_word", 32'(rd_a_data), 32'h5A5A);
        advance_clock();

        $display("[TB] scoreboard on GP5");
        apply_stimulus(0, 0, 0, 1, 5, 0, 0, 0, 0, 5, 5);
        check_output("sb_rsv");
        advance_clock();
        apply_stimulus(1, 5, 'h0055, 1, 5, 0, 0, 0, 0, 5, 5);
        check_output("sb_wr_rsv");
        check_val("sb.busy_set", 32'(rd_a_busy), 1);
        advance_clock();
        apply_stimulus(1, 5, 'h0066, 0, 0, 0, 0, 0, 0, 5, 4);
        check_output("sb_still");
        advance_clock();
        apply_stimulus(0, 0, 0, 1, NUM_GP + 1, 0, 0, 0, 0, 5, NUM_GP + 1);
        check_output("sb_clear");
        check_val("sb.busy_clear", 32'(rd_a_busy), 0);
        advance_clock();

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            apply_stimulus($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 65535),
                           $urandom_range(0, 2) == 0, $urandom_range(0, 15),
                           $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                           $urandom_range(0, 65535), $urandom_range(0, 2) == 0,
                           $urandom_range(0, 15), $urandom_range(0, 15));
            check_output("random");
            advance_clock();
        end

        $display("[TB] asynchronous reset mid-cycle");
        apply_stimulus(1, 2, 'h0042, 0, 0, 1, 1, 'h7777, 0, 2, PC_A);
        advance_clock();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, PC_A);
        check_output("pre_reset");
        check_val("pre_reset.full", 32'(bus_full), 1);
        check_val("pre_reset.gp2", 32'(rd_a_data), 32'h0042);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output("mid_reset");
        check_val("mid_reset.gp2", 32'(rd_a_data), 0);
        check_val("mid_reset.pc", 32'(pc_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
